// File: rtl/popcount_seq_if.sv
// Handshake bundle between the AM read port, popcount_seq and the compare stage.
// The slave modport is the popcount engine; master is whoever drives vectors in and takes results out.
interface popcount_seq_if #(
  parameter int N             = 2048,
  parameter int AM_ADDR_WIDTH = 13
);
  localparam int CW = $clog2(N + 1);

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic                     mode_i;
  logic [N-1:0]             data_a_i;
  logic [N-1:0]             data_b_i;
  logic [AM_ADDR_WIDTH-1:0] in_addr_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [CW-1:0]            count_o;
  logic [AM_ADDR_WIDTH-1:0] out_addr_o;

  modport slave (
    input  in_valid_i, mode_i, data_a_i, data_b_i, in_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, count_o, out_addr_o
  );

  modport master (
    output in_valid_i, mode_i, data_a_i, data_b_i, in_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, count_o, out_addr_o
  );
endinterface

// File: rtl/popcount_seq.sv
// Folded population count: W bits per cycle over N/W cycles, result held until consumed.
// Result registers are separate from the accumulator so count_o stays put while the next vector counts.
module popcount_seq #(
  parameter int N             = 2048,
  parameter int W             = 256,
  parameter int AM_ADDR_WIDTH = 13
) (
  input  logic         clk_i,
  input  logic         rst_i,
  popcount_seq_if.slave bus
);
  localparam int S  = N / W;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]               state_q,     state_d;
  logic [N-1:0]             operand_q,   operand_d;
  logic [AM_ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [CW-1:0]            acc_q,       acc_d;
  logic [IW-1:0]            idx_q,       idx_d;
  logic [CW-1:0]            count_q,     count_d;
  logic [AM_ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic                     out_valid_q, out_valid_d;

  logic          in_ready;
  logic          accept;
  logic [W-1:0]  slice;
  logic [CW-1:0] slice_cnt;

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready_i);
  assign accept    = bus.in_valid_i && in_ready;
  assign slice     = operand_q[int'(idx_q) * W +: W];
  assign slice_cnt = popcnt(slice);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    operand_d  = operand_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    count_d    = count_q;
    out_addr_d = out_addr_q;

    case (state_q)
      ST_IDLE: ;
      ST_COUNT: begin
        acc_d = acc_q + slice_cnt;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d    = ST_DONE;
          count_d    = acc_d;
          out_addr_d = addr_q;
        end
      end
      ST_DONE: if (bus.out_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the DONE->IDLE exit so a waiting vector starts in the same cycle the result leaves.
    if (accept) begin
      operand_d = bus.mode_i ? (bus.data_a_i ^ bus.data_b_i) : bus.data_a_i;
      addr_d    = bus.in_addr_i;
      acc_d     = '0;
      idx_d     = '0;
      state_d   = ST_COUNT;
    end

    out_valid_d = (state_d == ST_DONE);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values, matching hardware.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      operand_q   <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.count_o     = count_q;
  assign bus.out_addr_o  = out_addr_q;
endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: $countones-based transaction model checked every cycle, directed
// scenarios with literal expectations, a randomized phase, and a W = N instance for the S = 1 case.
module tb_popcount_seq;
  localparam int N  = 2048;
  localparam int W  = 256;
  localparam int AW = 13;
  localparam int S  = N / W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_seq_if #(.N(N), .AM_ADDR_WIDTH(AW)) bus  ();
  popcount_seq_if #(.N(N), .AM_ADDR_WIDTH(AW)) bus1 ();

  popcount_seq #(.N(N), .W(W), .AM_ADDR_WIDTH(AW)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  popcount_seq #(.N(N), .W(N), .AM_ADDR_WIDTH(AW)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
    end
  endtask

  // Transaction-level model: at most one pending result, ready S+1 cycles after its accept cycle.
  bit        model_live = 0;
  bit        pending    = 0;
  int        ready_at;
  int        pend_count, pend_addr;
  int        last_count = 0, last_addr = 0;
  bit        exp_valid, exp_ready;

  always @(negedge clk) begin
    exp_valid = pending && (cyc >= ready_at);
    exp_ready = !pending || (exp_valid && bus.out_ready_i);
    if (model_live) begin
      check("m_out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
      check("m_in_ready",  32'(bus.in_ready_o),  32'(exp_ready));
      check("m_count",     32'(bus.count_o),     exp_valid ? pend_count : last_count);
      check("m_out_addr",  32'(bus.out_addr_o),  exp_valid ? pend_addr  : last_addr);
    end
    if (rst) begin
      model_live = 1;
      pending    = 0;
      last_count = 0;
      last_addr  = 0;
    end else if (model_live) begin
      if (exp_valid && bus.out_ready_i) begin
        pending    = 0;
        last_count = pend_count;
        last_addr  = pend_addr;
      end
      if (bus.in_valid_i && exp_ready) begin
        pending    = 1;
        pend_count = $countones(bus.mode_i ? (bus.data_a_i ^ bus.data_b_i) : bus.data_a_i);
        pend_addr  = int'(bus.in_addr_i);
        ready_at   = cyc + S + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Present a vector, wait (bounded) for the handshake, return the accept cycle.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                      input logic [AW-1:0] ad, output int k);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.data_a_i   = a;
    bus.data_b_i   = b;
    bus.mode_i     = m;
    bus.in_addr_i  = ad;
    @(negedge clk);
    while (!bus.in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 200), 32'd1);
    k = cyc;
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic expect_result(input int k, input int cnt, input int ad, input string name);
    at_neg(k + S);
    check({name, "_early"}, 32'(bus.out_valid_o), 32'd0);
    at_neg(k + S + 1);
    check({name, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    check({name, "_count"}, 32'(bus.count_o), 32'(cnt));
    check({name, "_addr"},  32'(bus.out_addr_o), 32'(ad));
    tick();
  endtask

  function automatic logic [N-1:0] rand_vec(input int density);
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) begin
      v[i*32 +: 32] = $urandom;
      if (density == 1) v[i*32 +: 32] &= $urandom;
      if (density == 2) v[i*32 +: 32] |= $urandom;
    end
    return v;
  endfunction

  logic [N-1:0] ones, zeros, alt, edges, half_k;
  int           k, k2;

  initial begin
    ones   = '1;
    zeros  = '0;
    alt    = {1024{2'b10}};
    edges  = '0;
    edges[0] = 1'b1; edges[255] = 1'b1; edges[256] = 1'b1; edges[2047] = 1'b1;
    half_k = '0;
    half_k[511:0] = '1;

    bus.in_valid_i  = 1'b0; bus.mode_i = 1'b0; bus.data_a_i = '0; bus.data_b_i = '0;
    bus.in_addr_i   = '0;   bus.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0; bus1.mode_i = 1'b0; bus1.data_a_i = '0; bus1.data_b_i = '0;
    bus1.in_addr_i  = '0;   bus1.out_ready_i = 1'b1;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_count",     32'(bus.count_o),     32'd0);
    check("rst_addr",      32'(bus.out_addr_o),  32'd0);
    tick();

    // All ones with back-pressure held in DONE for 5 cycles.
    bus.out_ready_i = 1'b0;
    send(ones, zeros, 1'b0, 13'h1A5, k);
    at_neg(k + S);
    check("ones_early", 32'(bus.out_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      at_neg(k + S + 1 + i);
      check("bp_valid",    32'(bus.out_valid_o), 32'd1);
      check("bp_count",    32'(bus.count_o),     32'd2048);
      check("bp_addr",     32'(bus.out_addr_o),  32'h1A5);
      check("bp_in_ready", 32'(bus.in_ready_o),  32'd0);
    end
    tick();

    // Release with a vector waiting: accepted in the release cycle, then a COUNT-time pulse is ignored.
    bus.out_ready_i = 1'b1;
    send(ones, alt, 1'b1, 13'd2, k2);
    check("b2b_same_cycle", 32'(k2), 32'(k + S + 6));
    bus.in_valid_i = 1'b1;
    bus.data_a_i   = ones;
    bus.mode_i     = 1'b0;
    tick();
    bus.in_valid_i = 1'b0;
    expect_result(k2, 1024, 2, "hamming");

    send(alt, alt, 1'b1, 13'd3, k);
    expect_result(k, 0, 3, "a_eq_b");
    send(zeros, ones, 1'b0, 13'd4, k);
    expect_result(k, 0, 4, "zero_m0");
    send(edges, ones, 1'b0, 13'h1FFF, k);
    expect_result(k, 4, 13'h1FFF, "edges");

    // Reset mid-COUNT discards the vector; model keeps checking no result shows up.
    send(ones, zeros, 1'b0, 13'h0AB, k);
    while (cyc < k + 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",    32'(bus.out_valid_o), 32'd0);
    check("mid_rst_count",    32'(bus.count_o),     32'd0);
    check("mid_rst_addr",     32'(bus.out_addr_o),  32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready_o),  32'd1);
    repeat (12) tick();
    send(half_k, zeros, 1'b0, 13'd5, k);
    expect_result(k, 512, 5, "after_rst");

    // S = 1 instance: accept, result two cycles later, back-to-back every two cycles.
    bus1.in_valid_i = 1'b1;
    bus1.data_a_i   = edges;
    bus1.in_addr_i  = 13'h77;
    @(negedge clk);
    check("s1_in_ready", 32'(bus1.in_ready_o), 32'd1);
    k = cyc;
    at_neg(k + 1);
    check("s1_count_valid", 32'(bus1.out_valid_o), 32'd0);
    check("s1_count_ready", 32'(bus1.in_ready_o),  32'd0);
    at_neg(k + 2);
    check("s1_valid",  32'(bus1.out_valid_o), 32'd1);
    check("s1_count",  32'(bus1.count_o),     32'd4);
    check("s1_addr",   32'(bus1.out_addr_o),  32'h77);
    check("s1_b2b_rd", 32'(bus1.in_ready_o),  32'd1);
    tick();
    bus1.in_valid_i = 1'b0;
    at_neg(k + 3);
    check("s1_gap", 32'(bus1.out_valid_o), 32'd0);
    at_neg(k + 4);
    check("s1_b2b_valid", 32'(bus1.out_valid_o), 32'd1);
    check("s1_b2b_count", 32'(bus1.count_o),     32'd4);
    tick();

    // Randomized traffic: valid, data density, mode, back-pressure and the occasional reset.
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid_i  = ($urandom_range(0, 2) != 0);
      bus.mode_i      = $urandom_range(0, 1);
      bus.data_a_i    = rand_vec($urandom_range(0, 2));
      bus.data_b_i    = rand_vec($urandom_range(0, 2));
      bus.in_addr_i   = AW'($urandom);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
